// File: rtl/midi_message_parser.sv
// MIDI channel-voice message parser with running status, a WAIT_D2 timeout and real-time byte passthrough.
// Define MIDI_CHANNEL_FILTER_EN to emit only messages on FILTER_CHANNEL.
module midi_message_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 320_000,
  parameter logic [3:0]  FILTER_CHANNEL = 4'd0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       byte_valid_in,
  input  logic [7:0] byte_in,
  output logic       msg_valid_out,
  input  logic       msg_ready_in,
  output logic [3:0] msg_status_out,
  output logic [3:0] msg_channel_out,
  output logic [6:0] msg_data1_out,
  output logic [6:0] msg_data2_out,
  output logic       realtime_valid_out,
  output logic [7:0] realtime_byte_out,
  output logic       overflow_out
);

  localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef MIDI_CHANNEL_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {NO_STATUS, WAIT_D1, WAIT_D2} state_t;
  typedef enum logic [1:0] {CLS_DATA, CLS_CH, CLS_SYS, CLS_RT} byte_class_t;

  state_t           state;
  logic [3:0]       status_q;
  logic [3:0]       chan_q;
  logic             need2_q;
  logic [6:0]       d1_q;
  logic [CNT_W-1:0] timeout_cnt;

  byte_class_t byte_cls;
  logic        complete;
  logic [6:0]  cpl_d1;
  logic [6:0]  cpl_d2;
  logic        chan_ok;
  logic        deliver;
  logic        consume;
  logic        load;
  logic        drop;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    byte_cls = CLS_DATA;
    if (byte_in[7]) begin
      if (byte_in[7:3] == 5'b11111)   byte_cls = CLS_RT;
      else if (byte_in[7:4] == 4'hF)  byte_cls = CLS_SYS;
      else                            byte_cls = CLS_CH;
    end
  end

  // A message completes in the cycle its final data byte is strobed.
  always_comb begin
    complete = 1'b0;
    cpl_d1   = d1_q;
    cpl_d2   = 7'd0;
    if (byte_valid_in && byte_cls == CLS_DATA) begin
      unique case (state)
        WAIT_D1: begin
          if (!need2_q) begin
            complete = 1'b1;
            cpl_d1   = byte_in[6:0];
          end
        end
        WAIT_D2: begin
          complete = 1'b1;
          cpl_d2   = byte_in[6:0];
        end
        default: ;
      endcase
    end
  end

  assign chan_ok = !FILTER_EN || (chan_q == FILTER_CHANNEL);
  assign deliver = complete && chan_ok;
  assign consume = msg_valid_out && msg_ready_in;
  assign load    = deliver && (!msg_valid_out || msg_ready_in);
  assign drop    = deliver && msg_valid_out && !msg_ready_in;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state              <= NO_STATUS;
      status_q           <= 4'd0;
      chan_q             <= 4'd0;
      need2_q            <= 1'b0;
      d1_q               <= 7'd0;
      timeout_cnt        <= '0;
      msg_valid_out      <= 1'b0;
      msg_status_out     <= 4'd0;
      msg_channel_out    <= 4'd0;
      msg_data1_out      <= 7'd0;
      msg_data2_out      <= 7'd0;
      realtime_valid_out <= 1'b0;
      realtime_byte_out  <= 8'd0;
      overflow_out       <= 1'b0;
    end else begin
      realtime_valid_out <= byte_valid_in && (byte_cls == CLS_RT);
      if (byte_valid_in && byte_cls == CLS_RT) realtime_byte_out <= byte_in;

      // Real-time bytes fall through to the timeout branch: they neither advance nor reset parsing.
      if (byte_valid_in && byte_cls != CLS_RT) begin
        timeout_cnt <= '0;
        unique case (byte_cls)
          CLS_SYS: state <= NO_STATUS;
          CLS_CH: begin
            status_q <= byte_in[7:4];
            chan_q   <= byte_in[3:0];
            need2_q  <= (byte_in[7:4] != 4'hC) && (byte_in[7:4] != 4'hD);
            state    <= WAIT_D1;
          end
          CLS_DATA: begin
            unique case (state)
              WAIT_D1: begin
                if (need2_q) begin
                  d1_q  <= byte_in[6:0];
                  state <= WAIT_D2;
                end
              end
              WAIT_D2: state <= WAIT_D1;
              default: ;
            endcase
          end
          default: ;
        endcase
      end else if (state == WAIT_D2) begin
        if (timeout_cnt == CNT_LAST) state <= WAIT_D1;
        else                         timeout_cnt <= timeout_cnt + CNT_W'(1);
      end

      if (load) begin
        msg_valid_out   <= 1'b1;
        msg_status_out  <= status_q;
        msg_channel_out <= chan_q;
        msg_data1_out   <= cpl_d1;
        msg_data2_out   <= cpl_d2;
      end else if (consume) begin
        msg_valid_out <= 1'b0;
      end

      if (drop) overflow_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_midi_message_parser.sv
// Directed bench for midi_message_parser; short TIMEOUT_CYCLES keeps timeout scenarios brief.
module tb_midi_message_parser;

  localparam int unsigned TO = 64;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       byte_valid_in;
  logic [7:0] byte_in;
  logic       msg_valid_out;
  logic       msg_ready_in;
  logic [3:0] msg_status_out;
  logic [3:0] msg_channel_out;
  logic [6:0] msg_data1_out;
  logic [6:0] msg_data2_out;
  logic       realtime_valid_out;
  logic [7:0] realtime_byte_out;
  logic       overflow_out;

  int vectors     = 0;
  int miscompares = 0;

  midi_message_parser #(.TIMEOUT_CYCLES(TO), .FILTER_CHANNEL(4'd0)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .byte_valid_in      (byte_valid_in),
    .byte_in            (byte_in),
    .msg_valid_out      (msg_valid_out),
    .msg_ready_in       (msg_ready_in),
    .msg_status_out     (msg_status_out),
    .msg_channel_out    (msg_channel_out),
    .msg_data1_out      (msg_data1_out),
    .msg_data2_out      (msg_data2_out),
    .realtime_valid_out (realtime_valid_out),
    .realtime_byte_out  (realtime_byte_out),
    .overflow_out       (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; strobes one byte at the next posedge and returns at the following negedge.
  task automatic send(input logic [7:0] b);
    byte_valid_in = 1'b1;
    byte_in       = b;
    @(negedge clk_in);
    byte_valid_in = 1'b0;
    byte_in       = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic check_msg(input string tag, input logic [3:0] st, input logic [3:0] ch,
                           input logic [6:0] d1, input logic [6:0] d2);
    check({tag, "_valid"}, 8'(msg_valid_out), 8'h01);
    check({tag, "_status"}, 8'(msg_status_out), 8'(st));
    check({tag, "_chan"}, 8'(msg_channel_out), 8'(ch));
    check({tag, "_d1"}, 8'(msg_data1_out), 8'(d1));
    check({tag, "_d2"}, 8'(msg_data2_out), 8'(d2));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 8'(msg_valid_out), 8'h00);
    check({tag, "_status"}, 8'(msg_status_out), 8'h00);
    check({tag, "_chan"}, 8'(msg_channel_out), 8'h00);
    check({tag, "_d1"}, 8'(msg_data1_out), 8'h00);
    check({tag, "_d2"}, 8'(msg_data2_out), 8'h00);
    check({tag, "_rtv"}, 8'(realtime_valid_out), 8'h00);
    check({tag, "_rtb"}, realtime_byte_out, 8'h00);
    check({tag, "_ovf"}, 8'(overflow_out), 8'h00);
  endtask

  initial begin
    rst_in        = 1'b0;
    byte_valid_in = 1'b0;
    byte_in       = 8'h00;
    msg_ready_in  = 1'b0;
    idle(2);
    check_all_zero("reset");
    rst_in = 1'b1;
    idle(1);

    // Basic note-on, one-cycle latency.
    msg_ready_in = 1'b1;
    send(8'h90);
    send(8'h3C);
    check("t1_pre_valid", 8'(msg_valid_out), 8'h00);
    send(8'h64);
    check_msg("t1", 4'h9, 4'h0, 7'h3C, 7'h64);
    idle(1);
    check("t1_consumed", 8'(msg_valid_out), 8'h00);

    // Running status on channel 1.
    send(8'h91);
    send(8'h40);
    send(8'h7F);
    check_msg("rs1", 4'h9, 4'h1, 7'h40, 7'h7F);
    send(8'h41);
    check("rs_mid_valid", 8'(msg_valid_out), 8'h00);
    send(8'h00);
    check_msg("rs2", 4'h9, 4'h1, 7'h41, 7'h00);
    idle(1);

    // Program change: one data byte, completion reloads the register during a handshake.
    send(8'hC5);
    send(8'h0A);
    check_msg("pc1", 4'hC, 4'h5, 7'h0A, 7'h00);
    send(8'h0B);
    check_msg("pc2", 4'hC, 4'h5, 7'h0B, 7'h00);
    idle(1);
    check("pc_consumed", 8'(msg_valid_out), 8'h00);

    // Real-time byte interleaved mid-message.
    send(8'h90);
    send(8'h3C);
    send(8'hF8);
    check("rt_valid", 8'(realtime_valid_out), 8'h01);
    check("rt_byte", realtime_byte_out, 8'hF8);
    check("rt_no_msg", 8'(msg_valid_out), 8'h00);
    send(8'h64);
    check("rt_pulse_end", 8'(realtime_valid_out), 8'h00);
    check_msg("rt_msg", 4'h9, 4'h0, 7'h3C, 7'h64);
    idle(1);

    // System byte kills running status.
    send(8'h90);
    send(8'h3C);
    send(8'hF0);
    send(8'h64);
    check("sys_no_msg", 8'(msg_valid_out), 8'h00);
    idle(1);
    check("sys_no_msg_late", 8'(msg_valid_out), 8'h00);

    // Back-pressure: second message dropped, first held.
    msg_ready_in = 1'b0;
    send(8'h90);
    send(8'h3C);
    send(8'h64);
    check_msg("ovf_first", 4'h9, 4'h0, 7'h3C, 7'h64);
    check("ovf_before", 8'(overflow_out), 8'h00);
    send(8'h3D);
    send(8'h65);
    check("ovf_set", 8'(overflow_out), 8'h01);
    check_msg("ovf_held", 4'h9, 4'h0, 7'h3C, 7'h64);
    idle(2);
    check_msg("ovf_held_late", 4'h9, 4'h0, 7'h3C, 7'h64);
    msg_ready_in = 1'b1;
    idle(1);
    check("ovf_consumed", 8'(msg_valid_out), 8'h00);
    check("ovf_sticky", 8'(overflow_out), 8'h01);

    // Timeout abandons d1, running status kept.
    send(8'h90);
    send(8'h3C);
    idle(TO + 10);
    send(8'h40);
    check("to_wait_d2", 8'(msg_valid_out), 8'h00);
    send(8'h50);
    check_msg("to_msg", 4'h9, 4'h0, 7'h40, 7'h50);
    idle(1);

    // Last byte that still completes: strobe on the final counted cycle.
    send(8'h3C);
    idle(TO - 1);
    send(8'h41);
    check_msg("to_edge_in", 4'h9, 4'h0, 7'h3C, 7'h41);
    idle(1);

    // One cycle later the partial message is gone.
    send(8'h3C);
    idle(TO);
    send(8'h42);
    check("to_edge_out", 8'(msg_valid_out), 8'h00);
    send(8'h43);
    check_msg("to_edge_out_msg", 4'h9, 4'h0, 7'h42, 7'h43);
    idle(1);

    // Reset mid-message discards everything.
    send(8'h90);
    send(8'h3C);
    rst_in = 1'b0;
    idle(1);
    check_all_zero("mid_rst");
    rst_in = 1'b1;
    send(8'h40);
    send(8'h50);
    check("post_rst_no_msg", 8'(msg_valid_out), 8'h00);
    check("post_rst_ovf", 8'(overflow_out), 8'h00);
    idle(2);
    check("post_rst_no_msg_late", 8'(msg_valid_out), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/midi_message_parser.md
Name: midi_message_parser

Overview:
- Sits directly downstream of the MIDI UART byte receiver (31250 baud).
- Consumes the receiver's one-cycle byte strobes and assembles complete MIDI channel-voice messages, tracking running status.
- Hands each message to the synth voice/control logic over a single-entry valid/ready register.
- Passes real-time bytes (clock, start, stop) out as immediate pulses, independent of message parsing.

Parameters:
- TIMEOUT_CYCLES, 320_000, clk_in cycles in WAIT_D2 with no byte before the partial message is abandoned (3.2 ms at 100 MHz).
- FILTER_CHANNEL, 0, 4-bit channel accepted when MIDI_CHANNEL_FILTER_EN is defined; ignored otherwise.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-low
- byte_valid_in  input  1  one-cycle strobe, byte_in valid
- byte_in  input  8  received UART byte
- msg_valid_out  output  1  message register holds an unconsumed message
- msg_ready_in  input  1  consumer accepts when high together with msg_valid_out
- msg_status_out  output  4  status nibble, 0x8 to 0xE
- msg_channel_out  output  4  MIDI channel, 0 to 15
- msg_data1_out  output  7  first data byte
- msg_data2_out  output  7  second data byte; 0 for 1-data-byte messages (0xC, 0xD)
- realtime_valid_out  output  1  one-cycle pulse
- realtime_byte_out  output  8  real-time byte, 0xF8 to 0xFF
- overflow_out  output  1  sticky: a completed message was dropped

Behaviour:
- Reset: rst_in low at a clk_in edge forces all outputs to 0, clears running status and goes to NO_STATUS. A partial message in progress is discarded.
- Byte classes, evaluated only when byte_valid_in = 1:
  - RT (0xF8 to 0xFF): realtime_valid_out = 1 for one cycle and realtime_byte_out = byte on the next cycle. Parser state and timeout counter are untouched.
  - SYS (0xF0 to 0xF7): clears running status and goes to NO_STATUS. Subsequent data bytes are discarded.
  - CH (0x80 to 0xEF): latches status nibble and channel, sets need2 = (nibble not 0xC and not 0xD), goes to WAIT_D1. Any partial message is dropped.
  - DATA (0x00 to 0x7F): handled per state.
- States:
  - NO_STATUS: DATA is discarded.
  - WAIT_D1: on DATA, latch d1. If need2, go to WAIT_D2. Otherwise complete with d2 = 0 and stay in WAIT_D1 (running status).
  - WAIT_D2: on DATA, latch d2, complete, return to WAIT_D1.
- Timeout:
  - Counter clears on entry to WAIT_D2 and on every non-RT byte; it runs only in WAIT_D2.
  - On reaching TIMEOUT_CYCLES-1, the partial message is discarded and state returns to WAIT_D1 with running status kept.
  - WAIT_D1 never times out.
- Completion, in the cycle of the final data byte's strobe:
  - If msg_valid_out = 0, or msg_valid_out and msg_ready_in are both 1 in that cycle, load the message registers and assert msg_valid_out from the next cycle. Latency is 1 cycle.
  - Otherwise drop the new message and set overflow_out = 1. overflow_out stays high until reset.
- Handshake:
  - msg_valid_out and the msg_* fields hold stable until the cycle after msg_valid_out and msg_ready_in are both 1.
  - That cycle clears msg_valid_out unless a simultaneous completion reloads the register.
- Real-time byte and completion in adjacent cycles are independent; each output path is updated separately.
- Byte strobes arrive at most once per UART frame. The block must nevertheless accept strobes on consecutive cycles.

Optional Feature:
- Macro: MIDI_CHANNEL_FILTER_EN.
- Defined: messages whose channel differs from FILTER_CHANNEL are still parsed (running status and state advance as normal) but never loaded into the message register and never set overflow_out.
- Undefined: all 16 channels are emitted. The FILTER_CHANNEL parameter has no effect.

Test Plan:
- Strobes 0x90, 0x3C, 0x64 with msg_ready_in = 1 → msg_valid_out = 1 exactly one cycle after the third strobe, with status 0x9, channel 0, d1 0x3C, d2 0x64.
- Running status: 0x91, 0x40, 0x7F, 0x41, 0x00 → two messages on channel 1: (0x40, 0x7F), then (0x41, 0x00).
- Program change 0xC5, 0x0A, 0x0B → two messages, status 0xC, channel 5, d1 0x0A then 0x0B, d2 = 0 for both.
- 0x90, 0x3C, 0xF8, 0x64 → realtime_valid_out pulse with 0xF8; note message (0x3C, 0x64) is still delivered intact. Separately, 0x90, 0x3C, then 0xF0, 0x64 → no message.
- msg_ready_in held 0, two complete note-ons → first message is held unchanged, second is dropped, overflow_out = 1. Raise msg_ready_in → msg_valid_out clears the next cycle.
- 0x90, 0x3C, then idle for TIMEOUT_CYCLES+10, then 0x40, 0x50 → a single message (0x40, 0x50). Repeat with rst_in low after 0x3C → no message, all outputs 0.
